// File: rtl/keypad_digits_pkg.sv
// Shared keypad/lock types: the digit buffer, special key codes and the 4x3 key map.
// Also imported by the setup block, so keep it free of keypad_digits internals.
package keypad_digits_pkg;

  localparam int NUM_DIGITS = 20;

  localparam logic [3:0] KEY_STAR  = 4'hA;
  localparam logic [3:0] KEY_HASH  = 4'hB;
  localparam logic [3:0] KEY_EMPTY = 4'hF;

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] digits;
  } senhaPac_t;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_ACCEPT,
    ST_RELEASE
  } kp_state_e;

  localparam logic [3:0] KEY_MAP [4][3] = '{
    '{4'h1,     4'h2, 4'h3},
    '{4'h4,     4'h5, 4'h6},
    '{4'h7,     4'h8, 4'h9},
    '{KEY_STAR, 4'h0, KEY_HASH}
  };

  function automatic logic single_low(input logic [2:0] col);
    return (col == 3'b110) || (col == 3'b101) || (col == 3'b011);
  endfunction

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [2:0] col);
    logic [3:0] key;
    key = KEY_EMPTY;
    case (col)
      3'b110:  key = KEY_MAP[row][0];
      3'b101:  key = KEY_MAP[row][1];
      3'b011:  key = KEY_MAP[row][2];
      default: key = KEY_EMPTY;
    endcase
    return key;
  endfunction

  function automatic logic is_terminator(input logic [3:0] key);
    return (key == KEY_STAR) || (key == KEY_HASH);
  endfunction

endpackage

// File: rtl/keypad_digits_if.sv
// Keypad pins plus the digit stream handed to the lock's setup/operational blocks.
// master = keypad_digits, slave = keypad (columns) and digit consumer.
interface keypad_digits_if;
  import keypad_digits_pkg::*;

  logic [2:0] col_matriz;
  logic [3:0] lin_matriz;
  senhaPac_t  digitos_value;
  logic       digitos_valid;

  modport master (
    input  col_matriz,
    output lin_matriz,
    output digitos_value,
    output digitos_valid
  );

  modport slave (
    output col_matriz,
    input  lin_matriz,
    input  digitos_value,
    input  digitos_valid
  );

endinterface

// File: rtl/keypad_debouncer.sv
// Generic stable-for-CYCLES counter: done pulses on the CYCLES-th consecutive enabled,
// stable cycle. Any unstable or disabled cycle clears the count.
module keypad_debouncer #(
  parameter int CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic stable,
  output logic done
);

  localparam int W = $clog2(CYCLES) + 1;

  logic [W-1:0] count_q, count_d;
  logic         at_end;

  assign at_end = (count_q == W'(CYCLES - 1));
  assign done   = enable && stable && at_end;

  // Clearing on done keeps the counter from ever wrapping.
  always_comb begin
    count_d = '0;
    if (enable && stable && !at_end) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/keypad_digits.sv
// 4x3 keypad scanner: scan, debounce press, accept into the digit buffer, debounce release.
// Optional idle flush of the buffer is built when KEYPAD_TIMEOUT_EN is defined.
module keypad_digits
  import keypad_digits_pkg::*;
#(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int TIMEOUT_CYCLES  = 500000000
) (
  input  logic            clk,
  input  logic            rst,
  keypad_digits_if.master kp
);

  localparam int SCAN_W = $clog2(SCAN_CYCLES) + 1;

  kp_state_e          state_q, state_d;
  logic [1:0]         row_q, row_d;
  logic [3:0]         lin_q, lin_d;
  logic [2:0]         col_q, col_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  senhaPac_t          digits_q, digits_d;
  logic               valid_q, valid_d;
  logic [3:0]         key;
  logic               deb_enable, deb_stable, deb_done;

  assign key        = key_lookup(row_q, col_q);
  assign deb_enable = (state_q == ST_DEBOUNCE) || (state_q == ST_RELEASE);
  assign deb_stable = (state_q == ST_DEBOUNCE) ? (kp.col_matriz == col_q)
                                               : (kp.col_matriz == 3'b111);

  keypad_debouncer #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .rst    (rst),
    .enable (deb_enable),
    .stable (deb_stable),
    .done   (deb_done)
  );

`ifdef KEYPAD_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [IDLE_W-1:0] idle_q, idle_d;
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    scan_cnt_d = scan_cnt_q;
    digits_d   = digits_q;
    valid_d    = 1'b0;

    case (state_q)
      ST_SCAN: begin
        if (single_low(kp.col_matriz)) begin
          col_d      = kp.col_matriz;
          scan_cnt_d = '0;
          state_d    = ST_DEBOUNCE;
        end else if (scan_cnt_q == SCAN_W'(SCAN_CYCLES - 1)) begin
          scan_cnt_d = '0;
          row_d      = row_q + 1'b1;
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end
      // The shift and the valid pulse are registered together so the pulse
      // and the buffer holding the new key appear in the same cycle.
      ST_DEBOUNCE: begin
        if (kp.col_matriz != col_q) begin
          state_d = ST_SCAN;
        end else if (deb_done) begin
          digits_d.digits = {digits_q.digits[NUM_DIGITS-2:0], key};
          valid_d         = 1'b1;
          state_d         = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (is_terminator(key)) begin
          digits_d = '1;
        end
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (deb_done) begin
          row_d      = row_q + 1'b1;
          scan_cnt_d = '0;
          state_d    = ST_SCAN;
        end
      end
      default: state_d = ST_SCAN;
    endcase

`ifdef KEYPAD_TIMEOUT_EN
    idle_d = idle_q;
    if (state_q == ST_ACCEPT) begin
      idle_d = '0;
    end else if (state_q == ST_SCAN) begin
      if (digits_q == '1) begin
        idle_d = '0;
      end else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
        idle_d   = '0;
        digits_d = '1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
`endif

    lin_d = ~(4'b0001 << row_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SCAN;
      row_q      <= 2'd0;
      lin_q      <= 4'b1110;
      col_q      <= 3'b111;
      scan_cnt_q <= '0;
      digits_q   <= '1;
      valid_q    <= 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
      idle_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      lin_q      <= lin_d;
      col_q      <= col_d;
      scan_cnt_q <= scan_cnt_d;
      digits_q   <= digits_d;
      valid_q    <= valid_d;
`ifdef KEYPAD_TIMEOUT_EN
      idle_q     <= idle_d;
`endif
    end
  end

  assign kp.lin_matriz    = lin_q;
  assign kp.digitos_value = digits_q;
  assign kp.digitos_valid = valid_q;

endmodule

// File: tb/tb_keypad_digits.sv
// Directed bench for keypad_digits: a keypad model pulls columns low for pressed keys on
// the currently driven row; expected buffers are hand-computed constants.
module tb_keypad_digits;
  import keypad_digits_pkg::*;

  localparam int SCAN_CYCLES     = 4;
  localparam int DEBOUNCE_CYCLES = 8;
  localparam int TIMEOUT_CYCLES  = 100;

  logic        clk;
  logic        rst;
  logic [11:0] press;
  logic [2:0]  col_model;

  int checks;
  int errors;
  int pulse_cnt;
  int consec_cnt;
  logic prev_valid;

  keypad_digits_if kp_if ();

  keypad_digits #(
    .SCAN_CYCLES     (SCAN_CYCLES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pressed key at (r,c) shorts row r to column c; rows and columns are active-low.
  always_comb begin
    col_model = 3'b111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (press[r*3+c] && !kp_if.lin_matriz[r]) col_model[c] = 1'b0;
      end
    end
  end
  assign kp_if.col_matriz = col_model;

  initial begin
    pulse_cnt  = 0;
    consec_cnt = 0;
    prev_valid = 1'b0;
  end

  always @(negedge clk) begin
    if (kp_if.digitos_valid === 1'b1) begin
      pulse_cnt <= pulse_cnt + 1;
      if (prev_valid) consec_cnt <= consec_cnt + 1;
    end
    prev_valid <= (kp_if.digitos_valid === 1'b1);
  end

  task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int r, input int c, input int hold, input int rel);
    @(negedge clk);
    press[r*3+c] = 1'b1;
    repeat (hold) @(negedge clk);
    press[r*3+c] = 1'b0;
    repeat (rel) @(negedge clk);
  endtask

  task automatic pressDigit(input int d);
    if (d == 0) applyStimulus(3, 1, 40, 20);
    else        applyStimulus((d - 1) / 3, (d - 1) % 3, 40, 20);
  endtask

  task automatic waitValid(input int bound, output int cycles, output logic ok);
    ok     = 1'b0;
    cycles = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (kp_if.digitos_valid === 1'b1) begin
        cycles = i;
        ok     = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int        base;
    int        lat;
    logic      ok;
    senhaPac_t v;

    checks = 0;
    errors = 0;
    press  = '0;
    rst    = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("reset_lin",   80'(kp_if.lin_matriz), 80'(4'b1110));
    checkOutput("reset_value", kp_if.digitos_value, {80{1'b1}});
    checkOutput("reset_valid", 80'(kp_if.digitos_valid), 80'(1'b0));

    // Test 1: key '1' seen on the first scan cycle, then 2,3,4.
    $display("[TB] digits 1..4");
    rst   = 1'b0;
    press[0] = 1'b1;
    waitValid(40, lat, ok);
    checkOutput("t1_latency_seen", 80'(ok), 80'(1'b1));
    checkOutput("t1_latency", 80'(lat), 80'(DEBOUNCE_CYCLES + 1));
    repeat (30) @(negedge clk);
    press[0] = 1'b0;
    repeat (20) @(negedge clk);
    pressDigit(2);
    pressDigit(3);
    pressDigit(4);
    checkOutput("t1_pulses", 80'(pulse_cnt), 80'(4));
    checkOutput("t1_value", kp_if.digitos_value, 80'hFFFF_FFFF_FFFF_FFFF_1234);

    // Test 2: '*' terminator - pulse carries it, next cycle flushed.
    $display("[TB] star terminator");
    @(negedge clk);
    press[9] = 1'b1;
    waitValid(40, lat, ok);
    checkOutput("t2_valid_seen", 80'(ok), 80'(1'b1));
    v = kp_if.digitos_value;
    checkOutput("t2_digit0", 80'(v.digits[0]), 80'(4'hA));
    checkOutput("t2_digit1", 80'(v.digits[1]), 80'(4'h4));
    @(negedge clk);
    checkOutput("t2_flushed", kp_if.digitos_value, {80{1'b1}});
    repeat (30) @(negedge clk);
    press[9] = 1'b0;
    repeat (20) @(negedge clk);

    // Test 3: '8' bouncing every 3 clk, then stable.
    $display("[TB] bounce");
    base = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      press[7] = ~press[7];
      repeat (3) @(negedge clk);
    end
    press[7] = 1'b1;
    repeat (40) @(negedge clk);
    press[7] = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("t3_pulses", 80'(pulse_cnt - base), 80'(1));

    // Test 4: hold '5', add '6' while held, release in steps.
    $display("[TB] hold and rollover");
    base = pulse_cnt;
    @(negedge clk);
    press[4] = 1'b1;
    repeat (500) @(negedge clk);
    checkOutput("t4_hold_pulses", 80'(pulse_cnt - base), 80'(1));
    press[5] = 1'b1;
    repeat (50) @(negedge clk);
    press[4] = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("t4_second_key", 80'(pulse_cnt - base), 80'(1));
    press[5] = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("t4_after_release", 80'(pulse_cnt - base), 80'(1));
    checkOutput("t4_value", kp_if.digitos_value, 80'hFFFF_FFFF_FFFF_FFFF_FF85);

    // Test 5: two columns low on one row, then 21 digits into the 20-slot buffer.
    $display("[TB] two columns and overflow");
    base = pulse_cnt;
    @(negedge clk);
    press[6] = 1'b1;
    press[7] = 1'b1;
    repeat (60) @(negedge clk);
    press[6] = 1'b0;
    press[7] = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("t5_two_cols", 80'(pulse_cnt - base), 80'(0));
    for (int i = 0; i < 21; i++) pressDigit((i + 1) % 10);
    checkOutput("t5_pulses", 80'(pulse_cnt - base), 80'(21));
    v = kp_if.digitos_value;
    checkOutput("t5_oldest", 80'(v.digits[19]), 80'(4'h2));
    checkOutput("t5_value", kp_if.digitos_value, 80'h2345_6789_0123_4567_8901);

    // Test 6: enter '7' then stay idle well past the timeout.
    $display("[TB] idle");
    base = pulse_cnt;
    applyStimulus(2, 0, 40, 130);
    checkOutput("t6_pulses", 80'(pulse_cnt - base), 80'(1));
`ifdef KEYPAD_TIMEOUT_EN
    checkOutput("t6_timeout_flush", kp_if.digitos_value, {80{1'b1}});
`else
    checkOutput("t6_buffer_kept", kp_if.digitos_value, 80'h3456_7890_1234_5678_9017);
`endif

    // Reset while debouncing '3', key still held afterwards.
    $display("[TB] reset mid-press");
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (kp_if.lin_matriz == 4'b1110) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("r_row0_seen", 80'(ok), 80'(1'b1));
    press[2] = 1'b1;
    repeat (3) @(negedge clk);
    base = pulse_cnt;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("r_lin", 80'(kp_if.lin_matriz), 80'(4'b1110));
    checkOutput("r_value", kp_if.digitos_value, {80{1'b1}});
    checkOutput("r_valid", 80'(kp_if.digitos_valid), 80'(1'b0));
    rst = 1'b0;
    repeat (60) @(negedge clk);
    press[2] = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("r_pulses", 80'(pulse_cnt - base), 80'(1));
    checkOutput("r_value_after", kp_if.digitos_value, 80'hFFFF_FFFF_FFFF_FFFF_FFF3);

    checkOutput("valid_back_to_back", 80'(consec_cnt), 80'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
